srff_bank: RTL
==============

# srff_bank

Parametrised bank of WIDTH synchronous SR flip-flops with a selectable S=R=1 resolution mode, a load enable, per-bit sticky conflict flags and an optional saturating conflict counter. It is the multi-bit successor to the single SR flip-flop. It serves as a status/flag register wherever independent set/clear event sources drive shared state bits.

## Interface
Parameters:
- WIDTH, 8: number of flip-flops.
- MODE, 0: S=R=1 resolution. 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle.
- INIT, {WIDTH{1'b0}}: value loaded into Q on reset.
- CNT_W, 8: conflict counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR_N  in  1  synchronous active-low reset.
- EN  in  1  bank update enable.
- S  in  WIDTH  per-bit set request.
- R  in  WIDTH  per-bit reset request.
- CONF_CLR  in  1  clear for the sticky flags and the counter.
- Q  out  WIDTH  flip-flop state.
- QN  out  WIDTH  complement of Q.
- CONF  out  WIDTH  sticky per-bit S=R=1 flag.
- CONF_ANY  out  1  OR-reduction of CONF.
- CNT  out  CNT_W  saturating conflict-cycle counter.

## Operation
- Reset (CLR_N=0 at an edge): Q=INIT, QN=~INIT, CONF=0, CONF_ANY=0, CNT=0. Reset overrides EN, S, R and CONF_CLR.
- QN is always exactly ~Q. It is never high-Z and never equal to Q, including after reset.
- EN=0: Q holds regardless of S and R. No conflicts are recorded.
- EN=1, per bit i:
  - S=0, R=0: hold.
  - S=1, R=0: Q=1.
  - S=0, R=1: Q=0.
  - S=1, R=1: resolved by MODE. 0 holds, 1 sets, 2 clears, 3 inverts.
- Conflict: EN=1 and S[i]=R[i]=1. The conflict sets CONF[i]=1, and CONF[i] stays set until CONF_CLR or reset. A conflict is recorded in every MODE.
- CNT increments by 1 on each cycle in which any bit conflicts, however many bits conflict. CNT saturates at 2^CNT_W-1 and does not wrap.
- CONF_CLR=1: CONF=0 and CNT=0 at the edge. If a conflict occurs in the same cycle, the new conflict wins: the affected CONF bits are 1 and CNT=1.
- An out-of-range MODE parameter is treated as 0.
- Width rules: S and R are exactly WIDTH bits. No sign extension.

## Timing
- Q, QN, CONF, CONF_ANY and CNT are all registered.
- Latency is 1 cycle from the input edge to the output.
- There is no combinational path from any input to any output.
- Reset mid-operation takes effect at the next edge with CLR_N=0. Any in-flight conflict in that cycle is discarded.
- CONF_ANY is registered alongside CONF, so it always equals |CONF in the same cycle.

## Configuration
- Macro: SRFF_BANK_CONFLICT_CNT_EN.
- Defined: the CNT register and its increment, saturate and clear logic are present as described above.
- Undefined: there is no counter logic, and CNT is tied to 0. CONF and CONF_ANY behave identically in both builds.

## Test plan
- Reset with WIDTH=8, INIT=8'hA5: CLR_N=0 for 1 edge gives Q=8'hA5, QN=8'h5A, CONF=0, CNT=0. Repeat with S=R=8'hFF held during reset; the result is unchanged.
- Basic set/clear, MODE=0, EN=1, starting from Q=8'h00:
  - S=8'h0F, R=0 gives Q=8'h0F at the next edge.
  - Then S=0, R=8'h03 gives Q=8'h0C.
  - Then EN=0 with S=8'hF0 leaves Q=8'h0C.
- Mode sweep with Q=8'h0C and S=R=8'h06:
  - MODE=0 gives Q=8'h0C.
  - MODE=1 gives Q=8'h0E.
  - MODE=2 gives Q=8'h08.
  - MODE=3 gives Q=8'h0A.
  - In every mode CONF=8'h06, CONF_ANY=1 and CNT=1.
- Counter saturation with CNT_W=2: 5 consecutive conflict cycles give CNT sequence 1,2,3,3,3. With the macro undefined, CNT stays 0 throughout.
- Simultaneous clear and conflict: with CONF=8'h06 and CNT=3, apply CONF_CLR=1 together with S=R=8'h80 and EN=1. Result: CONF=8'h80, CNT=1. A following CONF_CLR alone gives CONF=0, CONF_ANY=0, CNT=0.

Source files
------------

// File: rtl/srff_bank.sv
// rtl/srff_bank.sv - bank of WIDTH synchronous SR flip-flops with conflict tracking
//
// Optional feature macro: SRFF_BANK_CONFLICT_CNT_EN (conflict-cycle counter present).
//
// Ports:
//   CLK       in   1      clock, rising edge
//   CLR_N     in   1      synchronous active-low reset
//   EN        in   1      bank update enable
//   S         in   WIDTH  per-bit set request
//   R         in   WIDTH  per-bit reset request
//   CONF_CLR  in   1      clear sticky conflict flags and counter
//   Q         out  WIDTH  flip-flop state
//   QN        out  WIDTH  complement of Q
//   CONF      out  WIDTH  sticky per-bit S=R=1 flag
//   CONF_ANY  out  1      OR of CONF
//   CNT       out  CNT_W  saturating conflict-cycle counter (0 when macro undefined)

module srff_bank #(
  parameter int               WIDTH = 8,
  parameter int               MODE  = 0,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
  parameter int               CNT_W = 8
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             CONF_CLR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic [WIDTH-1:0] CONF,
  output logic             CONF_ANY,
  output logic [CNT_W-1:0] CNT
);

  // Unknown resolution modes fall back to hold.
  localparam int MODE_EFF = (MODE >= 0 && MODE <= 3) ? MODE : 0;

  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] q_d, q_q;
  logic [WIDTH-1:0] qn_d, qn_q;
  logic [WIDTH-1:0] conf_d, conf_q;
  logic             conf_any_d, conf_any_q;

  always_comb begin
    hit = EN ? (S & R) : '0;
    q_d = q_q;
    if (EN) begin
      // Exclusive set/clear first; bits with S=R=1 are untouched here.
      q_d = (q_q | (S & ~R)) & ~(R & ~S);
    end
    case (MODE_EFF)
      1:       q_d = q_d | hit;
      2:       q_d = q_d & ~hit;
      3:       q_d = q_d ^ hit;
      default: q_d = q_d;
    endcase
    // QN gets its own flop so it is a clean registered complement.
    qn_d       = ~q_d;
    // A fresh conflict in the clearing cycle survives the clear.
    conf_d     = (CONF_CLR ? '0 : conf_q) | hit;
    conf_any_d = |conf_d;
  end

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      q_q        <= INIT;
      qn_q       <= ~INIT;
      conf_q     <= '0;
      conf_any_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      qn_q       <= qn_d;
      conf_q     <= conf_d;
      conf_any_q <= conf_any_d;
    end
  end

  assign Q        = q_q;
  assign QN       = qn_q;
  assign CONF     = conf_q;
  assign CONF_ANY = conf_any_q;

`ifdef SRFF_BANK_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = CONF_CLR ? '0 : cnt_q;
    // One increment per conflicting cycle, held at all-ones.
    if ((|hit) && (cnt_d != '1)) begin
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT = cnt_q;
`else
  assign CNT = '0;
`endif

endmodule
